fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
- Read-side controller for the team's variable-length FIFO.
- Drains exactly `len_i` words per stream from a FIFO whose read data is registered (one cycle after `rd_en`), and presents them on a valid/ready master port with a last flag.
- At end of stream it optionally pulses the FIFO's new-stream input to discard residue.
- Sits between the FIFO and a PE/consumer that may stall at any cycle.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and m_data_o.
- LEN_WIDTH, 8, width of the stream-length field; maximum stream length is 2^LEN_WIDTH-1 words.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- len_i  in  LEN_WIDTH  words to read; captured with start_i.
- flush_en_i  in  1  when 1, pulse fifo_new_stream_o at end of stream; captured with start_i.
- abort_i  in  1  terminate the current stream immediately.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_data_i  in  DATA_WIDTH  FIFO read data, valid one cycle after fifo_rd_en_o.
- fifo_rd_en_o  out  1  FIFO read enable.
- fifo_new_stream_o  out  1  FIFO pointer reset, one-cycle pulse.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  consumer ready.
- m_data_o  out  DATA_WIDTH  output word.
- m_last_o  out  1  marks the final word of the stream.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle end-of-stream pulse.

Behaviour:
- Reset (async, rst_ni=0): all outputs 0, FSM=IDLE, all counters 0, skid buffer empty.
- FSM states: IDLE, RUN, FINISH.
  - IDLE -> RUN on start_i with len_i>0.
  - IDLE -> FINISH on start_i with len_i=0. No reads are issued.
  - RUN -> FINISH when delivered==len, or on abort_i.
  - FINISH -> IDLE after exactly one cycle.
- FINISH cycle actions:
  - done_o=1.
  - fifo_new_stream_o=1 if captured flush_en, or if the stream was aborted.
- Read issue: fifo_rd_en_o=1 in RUN only when all of the following hold:
  - !fifo_empty_i;
  - issued<len;
  - !abort_i;
  - (occ + inflight - pop) < 2, where:
    - occ = skid occupancy, 0..2;
    - inflight = rd_en registered from the previous cycle;
    - pop = m_valid_o & m_ready_i.
- Data capture: on cycles where inflight=1, fifo_data_i is pushed into the 2-entry skid buffer.
- Skid buffer never overflows; an overflow is an assertion error.
- Throughput: one word per cycle sustained when FIFO non-empty and m_ready_i=1.
- Latency: start_i to first m_valid_o is 3 cycles with the FIFO non-empty:
  - start cycle → rd_en → capture → valid.
- Output port:
  - m_valid_o = (occ>0) in RUN.
  - m_data_o and m_last_o hold stable while m_valid_o & !m_ready_i.
  - m_last_o=1 exactly on the word with delivered index len-1.
- Counters: issued and delivered are LEN_WIDTH bits; increment on rd_en and on handshake respectively; no wrap is possible since both stop at len.
- start_i outside IDLE is ignored; len_i and flush_en_i are not re-sampled.
- abort_i in RUN:
  - reads stop the same cycle;
  - skid buffer is cleared next cycle;
  - an in-flight word returning next cycle is dropped;
  - m_valid_o=0 from the next cycle;
  - no m_last_o is generated.
- abort_i outside RUN is ignored.
- fifo_empty_i toggling mid-stream: reads pause; no words are lost or duplicated.
- Asynchronous reset mid-stream: immediate return to reset values; no done_o or new-stream pulse is generated.

Decomposition:
- Shared package: FSM state enum (IDLE/RUN/FINISH) and a SKID_DEPTH=2 constant.
- Sub-module stream_skid_buf:
  - 2-entry buffer with push, pop, clear, occ, and head data/last outputs.
  - Independently testable.

Test Plan:
- Stream, no stall: FIFO preloaded 0x10..0x14, start len=5, m_ready=1. Expect:
  - m_data 0x10..0x14 on 5 consecutive cycles;
  - m_last only with 0x14;
  - done_o one cycle later;
  - exactly 5 rd_en pulses.
- Backpressure: len=4, m_ready toggles 1,0,0,1,… Expect:
  - m_data held during stalls;
  - no word lost or duplicated;
  - occ never exceeds 2;
  - rd_en count=4.
- FIFO underrun: FIFO holds 2 words, len=4, 2 more written 5 cycles later. Expect:
  - reads pause while fifo_empty_i=1;
  - sequence complete and in order;
  - m_last on the 4th word.
- Zero length and flush: start len=0, flush_en=1. Expect:
  - no rd_en;
  - done_o and fifo_new_stream_o both 1 for one cycle, 1 cycle after start;
  - busy_o high for that cycle only.
- Abort: len=8, abort_i asserted after 3 handshakes with a read in flight. Expect:
  - rd_en low the same cycle;
  - m_valid_o=0 the next cycle;
  - fifo_new_stream_o and done_o pulse once;
  - no m_last_o.
- Reset mid-stream: rst_ni low during RUN with occ=2. Expect:
  - all outputs 0 asynchronously;
  - a subsequent start len=3 runs cleanly.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader and its skid buffer.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry skid buffer: entry 0 is always the head; entry 1 holds the next word.
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    input  logic                  clear_i,
    output logic [OCC_WIDTH-1:0]  occ_o,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  head_last_o
);

    localparam logic [OCC_WIDTH-1:0] FULL = OCC_WIDTH'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic [OCC_WIDTH-1:0]  base;
    logic                  pop_eff;

    assign pop_eff = pop_i && (occ_q != '0);
    assign base    = occ_q - OCC_WIDTH'(pop_eff);

    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        occ_d   = occ_q;
        if (clear_i) begin
            occ_d = '0;
        end else begin
            if (pop_eff) begin
                data0_d = data1_q;
                last0_d = last1_q;
            end
            // Push lands in the first free slot after this cycle's pop.
            if (push_i && (base != FULL)) begin
                if (base == '0) begin
                    data0_d = push_data_i;
                    last0_d = push_last_i;
                end else begin
                    data1_d = push_data_i;
                    last1_d = push_last_i;
                end
                occ_d = base + OCC_WIDTH'(1);
            end else begin
                occ_d = base;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            occ_q   <= '0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            occ_q   <= occ_d;
        end
    end

    assign occ_o       = occ_q;
    assign head_data_o = data0_q;
    assign head_last_o = last0_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !clear_i && (base == FULL)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller: drains len words from a registered-output FIFO onto a valid/ready port.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  flush_en_i,
    input  logic                  abort_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_en_o,
    output logic                  fifo_new_stream_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned PW = OCC_WIDTH + 1;
    localparam logic [PW-1:0] LIMIT = PW'(SKID_DEPTH);

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] issued_q, issued_d;
    logic [LEN_WIDTH-1:0] delivered_q, delivered_d;
    logic                 flush_q, flush_d;
    logic                 aborted_q, aborted_d;
    logic                 inflight_q;

    logic [OCC_WIDTH-1:0]  occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic [PW-1:0]         pending;
    logic                  in_run, valid, pop, push, push_last, clear, rd_en;

    assign in_run  = (state_q == ST_RUN);
    assign valid   = in_run && (occ != '0);
    assign pop     = valid && m_ready_i;
    // Words already owned (buffered or returning) after this cycle's pop must leave room.
    assign pending = PW'(occ) + PW'(inflight_q) - PW'(pop);
    assign rd_en   = in_run && !fifo_empty_i && (issued_q < len_q) && !abort_i
                     && (pending < LIMIT);

    // The returning word's index is issued_q-1, so it is the last one when issued_q==len_q.
    assign push      = in_run && inflight_q;
    assign push_last = (issued_q == len_q);
    assign clear     = (in_run && abort_i) || ((state_q == ST_IDLE) && start_i);

    stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (fifo_data_i),
        .push_last_i (push_last),
        .pop_i       (pop),
        .clear_i     (clear),
        .occ_o       (occ),
        .head_data_o (head_data),
        .head_last_o (head_last)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        flush_d     = flush_q;
        aborted_d   = aborted_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d       = len_i;
                    flush_d     = flush_en_i;
                    issued_d    = '0;
                    delivered_d = '0;
                    aborted_d   = 1'b0;
                    state_d     = (len_i == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_en) issued_d = issued_q + LEN_WIDTH'(1);
                if (pop)   delivered_d = delivered_q + LEN_WIDTH'(1);
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = ST_FINISH;
                end else if ((pop && head_last) || (delivered_q == len_q)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            flush_q     <= 1'b0;
            aborted_q   <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            flush_q     <= flush_d;
            aborted_q   <= aborted_d;
            inflight_q  <= rd_en;
        end
    end

    assign fifo_rd_en_o      = rd_en;
    assign fifo_new_stream_o = (state_q == ST_FINISH) && (flush_q || aborted_q);
    assign m_valid_o         = valid;
    assign m_data_o          = head_data;
    assign m_last_o          = valid && head_last;
    assign busy_o            = (state_q != ST_IDLE);
    assign done_o            = (state_q == ST_FINISH);

endmodule
